// File: rtl/err_pkg.sv
// Shared constants and state encoding for the error-report arbiter.
package err_pkg;

   localparam int unsigned ERR_NUM   = 8;
   localparam int unsigned ERR_IDX_W = 3;

   typedef enum logic [1:0] {
      ERR_ST_IDLE  = 2'd0,
      ERR_ST_ISSUE = 2'd1,
      ERR_ST_ACK   = 2'd2
   } err_state_e;

   // One-hot vector with bit idx set.
   function automatic logic [ERR_NUM-1:0] err_onehot(input logic [ERR_IDX_W-1:0] idx);
      logic [ERR_NUM-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/err_arb_if.sv
// Error request / report bundle between the sources, the arbiter and the link layer.
interface err_arb_if;
   import err_pkg::*;

   logic [ERR_NUM-1:0]   err_req;
   logic [ERR_NUM-1:0]   err_ack;
   logic                 err_valid;
   logic [ERR_IDX_W-1:0] err_code;
   logic                 err_ready;
   logic                 err_busy;
   logic                 err_timeout;

   // Arbiter side.
   modport master (
      input  err_req, err_ready,
      output err_ack, err_valid, err_code, err_busy, err_timeout
   );

   // Environment side: request sources and link layer.
   modport slave (
      output err_req, err_ready,
      input  err_ack, err_valid, err_code, err_busy, err_timeout
   );

endinterface

// File: rtl/err_rr_pick.sv
// Combinational round-robin picker: first set bit of eligible at or above ptr, modulo 8.
module err_rr_pick
   import err_pkg::*;
(
   input  logic [ERR_NUM-1:0]   eligible,
   input  logic [ERR_IDX_W-1:0] ptr,
   output logic                 found,
   output logic [ERR_IDX_W-1:0] idx
);

   logic [ERR_IDX_W-1:0] cand;

   // Scan from the farthest offset down so the nearest candidate to ptr wins last.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int k = ERR_NUM - 1; k >= 0; k--) begin
         cand = ptr + ERR_IDX_W'(k);
         if (eligible[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/err_arb.sv
// Round-robin error-report arbiter: grants one source at a time, offers it to the link layer,
// then acknowledges it and masks it until its request drops.
// Optional feature: define ERR_ARB_TIMEOUT_EN to drop reports after C_TIMEOUT stalled cycles.
module err_arb
   import err_pkg::*;
#(
   parameter int unsigned C_NUM     = 8,
   parameter int unsigned C_TIMEOUT = 255
) (
   input logic        phyclk,
   input logic        phyreset,
   err_arb_if.master  bus
);

   err_state_e           state_q, state_d;
   logic [ERR_IDX_W-1:0] index_q, index_d;
   logic [ERR_IDX_W-1:0] ptr_q, ptr_d;
   logic [ERR_NUM-1:0]   mask_q, mask_d;
   logic [ERR_NUM-1:0]   ack_q, ack_d;
   logic [ERR_NUM-1:0]   mask_set;
   logic [ERR_NUM-1:0]   eligible;
   logic                 pick_found;
   logic [ERR_IDX_W-1:0] pick_idx;
   logic                 unused_cfg;

   // Only C_NUM == 8 is supported; the value is not otherwise consumed.
   assign unused_cfg = ^{C_NUM[0], C_TIMEOUT[0]};

   assign eligible = bus.err_req & ~mask_q;

   err_rr_pick u_pick (
      .eligible (eligible),
      .ptr      (ptr_q),
      .found    (pick_found),
      .idx      (pick_idx)
   );

`ifdef ERR_ARB_TIMEOUT_EN
   localparam logic [7:0] TimeoutLast = 8'(C_TIMEOUT - 1);

   logic [7:0] cnt_q, cnt_d;
   logic       tmo_q, tmo_d;
`endif

   // Next-state, grant latch and ack generation.
   always_comb begin
      state_d  = state_q;
      index_d  = index_q;
      ptr_d    = ptr_q;
      ack_d    = '0;
      mask_set = '0;
`ifdef ERR_ARB_TIMEOUT_EN
      cnt_d    = cnt_q;
      tmo_d    = 1'b0;
`endif
      unique case (state_q)
         ERR_ST_IDLE: begin
            if (pick_found) begin
               index_d = pick_idx;
               ptr_d   = pick_idx + 3'd1;
               state_d = ERR_ST_ISSUE;
`ifdef ERR_ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         ERR_ST_ISSUE: begin
            if (bus.err_ready) begin
               state_d  = ERR_ST_ACK;
               ack_d    = err_onehot(index_q);
               mask_set = err_onehot(index_q);
            end
`ifdef ERR_ARB_TIMEOUT_EN
            else if (cnt_q == TimeoutLast) begin
               // Link layer stalled too long: retire the report as if accepted.
               state_d  = ERR_ST_ACK;
               ack_d    = err_onehot(index_q);
               mask_set = err_onehot(index_q);
               tmo_d    = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
         end
         ERR_ST_ACK: state_d = ERR_ST_IDLE;
         default:    state_d = ERR_ST_IDLE;
      endcase
      // A dropped request clears its mask bit, but a same-edge set takes priority.
      mask_d = (mask_q & bus.err_req) | mask_set;
   end

   // State and datapath registers.
   always_ff @(posedge phyclk or posedge phyreset) begin
      if (phyreset) begin
         state_q <= ERR_ST_IDLE;
         index_q <= '0;
         ptr_q   <= '0;
         mask_q  <= '0;
         ack_q   <= '0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         ptr_q   <= ptr_d;
         mask_q  <= mask_d;
         ack_q   <= ack_d;
      end
   end

`ifdef ERR_ARB_TIMEOUT_EN
   // Stall counter and timeout pulse.
   always_ff @(posedge phyclk or posedge phyreset) begin
      if (phyreset) begin
         cnt_q <= '0;
         tmo_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tmo_q <= tmo_d;
      end
   end

   assign bus.err_timeout = tmo_q;
`else
   assign bus.err_timeout = 1'b0;
`endif

   assign bus.err_valid = (state_q == ERR_ST_ISSUE);
   assign bus.err_code  = index_q;
   assign bus.err_ack   = ack_q;
   assign bus.err_busy  = (state_q != ERR_ST_IDLE);

endmodule

// File: tb/tb_err_arb.sv
// Self-checking bench for err_arb: directed vector table, hand-written corner sequences and a
// randomized run checked against a transaction-level reference model.
module tb_err_arb;
   import err_pkg::*;

`ifdef ERR_ARB_TIMEOUT_EN
   localparam int unsigned TO = 4;
`else
   localparam int unsigned TO = 255;
`endif

   logic phyclk = 1'b0;
   logic phyreset;

   err_arb_if bus ();

   err_arb #(
      .C_NUM     (8),
      .C_TIMEOUT (TO)
   ) dut (
      .phyclk   (phyclk),
      .phyreset (phyreset),
      .bus      (bus)
   );

   always #5 phyclk = ~phyclk;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic       rst;
      logic [7:0] req;
      logic       rdy;
      logic       v;
      logic [2:0] c;
      logic [7:0] a;
      logic       b;
   } vec_t;

   vec_t tbl[16];

   // Reference model state: transaction phase 0 idle, 1 offering, 2 acking.
   int  m_mode;
   int  m_code;
   int  m_ptr;
   int  m_stall;
   bit  m_tmo;
   bit  m_pend[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge phyclk);
      @(negedge phyclk);
   endtask

   task automatic do_reset();
      phyreset       = 1'b1;
      bus.err_req    = '0;
      bus.err_ready  = 1'b0;
      step();
      phyreset = 1'b0;
   endtask

   function automatic void model_reset();
      m_mode  = 0;
      m_code  = 0;
      m_ptr   = 0;
      m_stall = 0;
      m_tmo   = 1'b0;
      for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
   endfunction

   // Predict the state after one clock edge given the inputs held across that edge.
   function automatic void model_step(input logic [7:0] req, input logic rdy);
      int  nxt;
      bit  found;
      bit  do_set;
      bit  limit;
      nxt    = m_mode;
      found  = 1'b0;
      do_set = 1'b0;
      m_tmo  = 1'b0;
      if (m_mode == 0) begin
         for (int k = 0; k < 8; k++) begin
            int j;
            j = (m_ptr + k) % 8;
            if (!found && req[j] && !m_pend[j]) begin
               found   = 1'b1;
               m_code  = j;
               m_ptr   = (j + 1) % 8;
               nxt     = 1;
               m_stall = 0;
            end
         end
      end else if (m_mode == 1) begin
`ifdef ERR_ARB_TIMEOUT_EN
         limit = (m_stall + 1 >= int'(TO));
`else
         limit = 1'b0;
`endif
         if (rdy || limit) begin
            nxt    = 2;
            do_set = 1'b1;
            m_tmo  = !rdy;
         end else begin
            m_stall++;
         end
      end else begin
         nxt = 0;
      end
      for (int i = 0; i < 8; i++) if (!req[i]) m_pend[i] = 1'b0;
      if (do_set) m_pend[m_code] = 1'b1;
      m_mode = nxt;
   endfunction

   task automatic check_model(input int cyc);
      logic [7:0] exp_ack;
      exp_ack = (m_mode == 2) ? (8'h01 << m_code) : 8'h00;
      check($sformatf("rnd%0d valid", cyc), 32'(bus.err_valid), 32'(m_mode == 1));
      check($sformatf("rnd%0d code", cyc), 32'(bus.err_code), 32'(m_code));
      check($sformatf("rnd%0d ack", cyc), 32'(bus.err_ack), 32'(exp_ack));
      check($sformatf("rnd%0d busy", cyc), 32'(bus.err_busy), 32'(m_mode != 0));
      check($sformatf("rnd%0d timeout", cyc), 32'(bus.err_timeout), 32'(m_tmo));
   endtask

   initial begin
      // rst, req, ready | valid, code, ack, busy
      tbl[0]  = '{1'b0, 8'h04, 1'b1, 1'b1, 3'd2, 8'h00, 1'b1};
      tbl[1]  = '{1'b0, 8'h04, 1'b1, 1'b0, 3'd2, 8'h04, 1'b1};
      tbl[2]  = '{1'b0, 8'h04, 1'b1, 1'b0, 3'd2, 8'h00, 1'b0};
      tbl[3]  = '{1'b0, 8'h04, 1'b1, 1'b0, 3'd2, 8'h00, 1'b0};
      tbl[4]  = '{1'b0, 8'h04, 1'b1, 1'b0, 3'd2, 8'h00, 1'b0};
      tbl[5]  = '{1'b1, 8'h81, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};
      tbl[6]  = '{1'b0, 8'h81, 1'b1, 1'b1, 3'd0, 8'h00, 1'b1};
      tbl[7]  = '{1'b0, 8'h81, 1'b1, 1'b0, 3'd0, 8'h01, 1'b1};
      tbl[8]  = '{1'b0, 8'h81, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};
      tbl[9]  = '{1'b0, 8'h81, 1'b1, 1'b1, 3'd7, 8'h00, 1'b1};
      tbl[10] = '{1'b0, 8'h81, 1'b1, 1'b0, 3'd7, 8'h80, 1'b1};
      tbl[11] = '{1'b0, 8'h81, 1'b1, 1'b0, 3'd7, 8'h00, 1'b0};
      tbl[12] = '{1'b0, 8'h81, 1'b1, 1'b0, 3'd7, 8'h00, 1'b0};
      tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd7, 8'h00, 1'b0};
      tbl[14] = '{1'b0, 8'h81, 1'b1, 1'b1, 3'd0, 8'h00, 1'b1};
      tbl[15] = '{1'b0, 8'h81, 1'b1, 1'b0, 3'd0, 8'h01, 1'b1};

      phyreset      = 1'b1;
      bus.err_req   = '0;
      bus.err_ready = 1'b0;
      @(negedge phyclk);

      // Reset state.
      do_reset();
      check("reset valid", 32'(bus.err_valid), 32'd0);
      check("reset code", 32'(bus.err_code), 32'd0);
      check("reset ack", 32'(bus.err_ack), 32'd0);
      check("reset busy", 32'(bus.err_busy), 32'd0);
      check("reset timeout", 32'(bus.err_timeout), 32'd0);

      // Directed vectors: single source, mask hold, reset, two-source round robin.
      for (int i = 0; i < 16; i++) begin
         phyreset      = tbl[i].rst;
         bus.err_req   = tbl[i].req;
         bus.err_ready = tbl[i].rdy;
         step();
         check($sformatf("vec%0d valid", i), 32'(bus.err_valid), 32'(tbl[i].v));
         check($sformatf("vec%0d code", i), 32'(bus.err_code), 32'(tbl[i].c));
         check($sformatf("vec%0d ack", i), 32'(bus.err_ack), 32'(tbl[i].a));
         check($sformatf("vec%0d busy", i), 32'(bus.err_busy), 32'(tbl[i].b));
         check($sformatf("vec%0d timeout", i), 32'(bus.err_timeout), 32'd0);
         phyreset = 1'b0;
      end

`ifdef ERR_ARB_TIMEOUT_EN
      // Stuck link layer: report is retired with ack and timeout together after 4 ISSUE cycles.
      do_reset();
      bus.err_req   = 8'h01;
      bus.err_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("tmo issue%0d valid", i), 32'(bus.err_valid), 32'd1);
         check($sformatf("tmo issue%0d timeout", i), 32'(bus.err_timeout), 32'd0);
      end
      step();
      check("tmo ack", 32'(bus.err_ack), 32'h01);
      check("tmo pulse", 32'(bus.err_timeout), 32'd1);
      check("tmo valid low", 32'(bus.err_valid), 32'd0);
      step();
      check("tmo pulse end", 32'(bus.err_timeout), 32'd0);
      check("tmo ack end", 32'(bus.err_ack), 32'h00);
`else
      // Long stall: offer stays stable, ack follows the cycle after ready rises.
      do_reset();
      bus.err_req   = 8'h01;
      bus.err_ready = 1'b0;
      step();
      check("stall enter valid", 32'(bus.err_valid), 32'd1);
      for (int i = 0; i < 10; i++) begin
         step();
         check($sformatf("stall%0d valid", i), 32'(bus.err_valid), 32'd1);
         check($sformatf("stall%0d code", i), 32'(bus.err_code), 32'd0);
         check($sformatf("stall%0d ack", i), 32'(bus.err_ack), 32'h00);
         check($sformatf("stall%0d timeout", i), 32'(bus.err_timeout), 32'd0);
      end
      bus.err_ready = 1'b1;
      step();
      check("stall release ack", 32'(bus.err_ack), 32'h01);
      check("stall release valid", 32'(bus.err_valid), 32'd0);
`endif

      // Re-raise after ack: held request is masked, a one-cycle drop re-arms it.
      do_reset();
      bus.err_req   = 8'h08;
      bus.err_ready = 1'b1;
      step();
      check("rearm first code", 32'(bus.err_code), 32'd3);
      step();
      check("rearm first ack", 32'(bus.err_ack), 32'h08);
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("rearm hold%0d valid", i), 32'(bus.err_valid), 32'd0);
         check($sformatf("rearm hold%0d busy", i), 32'(bus.err_busy), 32'd0);
      end
      bus.err_req = 8'h00;
      step();
      check("rearm drop valid", 32'(bus.err_valid), 32'd0);
      bus.err_req = 8'h08;
      step();
      check("rearm second valid", 32'(bus.err_valid), 32'd1);
      check("rearm second code", 32'(bus.err_code), 32'd3);

      // Request dropping while offered still completes with an ack.
      do_reset();
      bus.err_req   = 8'h20;
      bus.err_ready = 1'b0;
      step();
      bus.err_req   = 8'h00;
      bus.err_ready = 1'b1;
      step();
      check("drop in issue ack", 32'(bus.err_ack), 32'h20);

      // Reset in ISSUE: outputs clear at once, the held request is re-reported afterwards.
      do_reset();
      bus.err_req   = 8'h10;
      bus.err_ready = 1'b0;
      step();
      check("rst issue valid", 32'(bus.err_valid), 32'd1);
      check("rst issue code", 32'(bus.err_code), 32'd4);
      phyreset = 1'b1;
      #1;
      check("rst async valid", 32'(bus.err_valid), 32'd0);
      check("rst async code", 32'(bus.err_code), 32'd0);
      check("rst async busy", 32'(bus.err_busy), 32'd0);
      check("rst async ack", 32'(bus.err_ack), 32'h00);
      @(negedge phyclk);
      phyreset      = 1'b0;
      bus.err_ready = 1'b1;
      step();
      check("rst rearb valid", 32'(bus.err_valid), 32'd1);
      check("rst rearb code", 32'(bus.err_code), 32'd4);
      step();
      check("rst rearb ack", 32'(bus.err_ack), 32'h10);

      // Randomized traffic against the reference model.
      do_reset();
      model_reset();
      for (int cyc = 0; cyc < 800; cyc++) begin
         if ($urandom_range(0, 3) == 0) bus.err_req = 8'($urandom);
         bus.err_ready = ($urandom_range(0, 2) != 0);
         model_step(bus.err_req, bus.err_ready);
         step();
         check_model(cyc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/err_arb.md
ERR_ARB -- requirements
Module: err_arb

Interface
REQ-001 SHALL have parameter C_NUM, default 8, meaning number of error sources; the only supported value is 8.
REQ-002 SHALL have parameter C_TIMEOUT, default 255, meaning the ready-wait limit in phyclk cycles; it is used only under ERR_ARB_TIMEOUT_EN.
REQ-003 SHALL have port phyclk, input, 1, the single clock for the whole block.
REQ-004 SHALL have port phyreset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port err_req, input, 8, level error requests already synchronised into phyclk.
REQ-006 SHALL have port err_ack, output, 8, one-cycle acknowledge pulse per source, returned to the sticky-status clear path.
REQ-007 SHALL have port err_valid, output, 1, error report offered to the link layer.
REQ-008 SHALL have port err_code, output, 3, index of the reported source.
REQ-009 SHALL have port err_ready, input, 1, link layer accepts the report.
REQ-010 SHALL have port err_busy, output, 1, high whenever the state is not IDLE.
REQ-011 SHALL have port err_timeout, output, 1, one-cycle pulse on a dropped report; it is tied 0 without ERR_ARB_TIMEOUT_EN.

Function
REQ-012 SHALL implement states IDLE, ISSUE and ACK.
REQ-013 Eligible set SHALL be err_req & ~mask, where mask is an 8-bit register of sources already acknowledged but whose err_req has not yet dropped.
REQ-014 In IDLE with eligible nonzero at edge N, the block SHALL latch the granted index and enter ISSUE, with err_valid=1 and err_code=index from cycle N+1.
REQ-015 Grant SHALL be round-robin: the search starts at pointer ptr and ascends modulo 8; ptr becomes index+1 (7 wraps to 0) when the grant is latched.
REQ-016 In ISSUE, err_valid and err_code SHALL stay stable until a cycle with err_ready=1, then the block enters ACK; err_ready outside ISSUE SHALL be ignored.
REQ-017 In ACK, err_ack[index] SHALL be 1 for exactly one cycle, all other ack bits 0, and mask[index] SHALL be set at the same edge; the next state is IDLE.
REQ-018 mask[i] SHALL clear on any edge where err_req[i]=0; when a set and a clear hit the same bit on the same edge, the set wins.
REQ-019 A request dropping while granted (ISSUE) SHALL NOT abort the report; the report completes and is acked.
REQ-020 Minimum spacing between grants SHALL be 3 cycles (IDLE, ISSUE, ACK); there is no back-to-back bypass.
REQ-021 err_ack SHALL be registered, with at most one bit set at a time.

Reset
REQ-022 On phyreset, asynchronously: state=IDLE, mask=0, ptr=0, index=0, err_ack=0, err_valid=0, err_code=0, err_timeout=0, timeout counter=0.
REQ-023 Reset mid-ISSUE or mid-ACK SHALL drop the report without an ack; the still-high err_req then re-arbitrates after reset.

Configuration
REQ-024 With macro ERR_ARB_TIMEOUT_EN defined, an 8-bit counter SHALL run in ISSUE; after C_TIMEOUT cycles with err_ready=0, the block enters ACK (ack issued, mask set) and pulses err_timeout in that ACK cycle.
REQ-025 Without ERR_ARB_TIMEOUT_EN, ISSUE SHALL wait for err_ready indefinitely, no counter SHALL be built, and err_timeout SHALL be constant 0.

Structure
REQ-026 Shared package err_pkg SHALL hold ERR_NUM=8, ERR_IDX_W=3 and the state encodings ERR_ST_IDLE/ISSUE/ACK.
REQ-027 Round-robin selection SHALL be a sub-module err_rr_pick, purely combinational: inputs eligible[7:0] and ptr[2:0], outputs found and idx[2:0].

Verification
REQ-028 Reset, then err_req=8'h04 with err_ready tied 1 -> err_valid/err_code=2 one cycle after request seen, err_ack=8'h04 next cycle, no further grant while err_req[2] is held.
REQ-029 err_req=8'h81 with ptr=0 and err_ready=1 -> grant order is code 0 then code 7, each acked once; ptr ends at 0.
REQ-030 err_ready held 0 for 10 cycles in ISSUE -> err_valid and err_code stable for all 10 cycles; ack appears the cycle after err_ready rises.
REQ-031 Ack bit 3, keep err_req[3] high 5 cycles, drop it 1 cycle, raise it again -> second report of code 3 issued after re-raise.
REQ-032 With ERR_ARB_TIMEOUT_EN and C_TIMEOUT=4, err_ready stuck 0 -> err_timeout and err_ack pulse together after 4 ISSUE cycles.
REQ-033 phyreset asserted during ISSUE with err_req=8'h10 -> outputs 0 immediately, then code 4 is re-reported after release.
